// File: rtl/reg6_handshake.sv
// reg6_handshake
//   Data register that is loaded through a four-phase request/acknowledge
//   handshake. On the first edge where en is seen high while armed, the block
//   captures data_in once and raises fim. It holds both outputs until en is
//   seen low, and then re-arms.
//
// Ports
//   clk      : system clock (rising edge)
//   rst      : synchronous, active-high reset
//   en       : load request; data_in is valid while high
//   data_in  : word to capture (WIDTH bits)
//   data_out : registered captured word
//   fim      : registered done/acknowledge flag
module reg6_handshake #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fim
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             fim_q,   fim_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      fim_q   <= fim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fim_d   = fim_q;
    unique case (state_q)
      IDLE: begin
        fim_d = 1'b0;
        if (en) begin
          data_d  = data_in;
          fim_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Capture happens only once per handshake; the block waits here
        // until the producer drops en.
        fim_d = 1'b1;
        if (!en) begin
          fim_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fim_d   = 1'b0;
      end
    endcase
  end

  assign data_out = data_q;
  assign fim      = fim_q;

endmodule

// File: tb/tb_reg6_handshake.sv
module tb_reg6_handshake;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             fim;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model: the last word handed over, and whether a handshake is
  // still open (captured, waiting for the producer to release en).
  logic [WIDTH-1:0] m_word;
  bit               m_open;

  reg6_handshake #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in),
    .data_out (data_out),
    .fim      (fim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, and then
  // compare both outputs shortly after the edge.
  task automatic cycle(input string tag, input logic r, input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst     = r;
    en      = e;
    data_in = d;
    @(posedge clk);
    if (r) begin
      m_word = '0;
      m_open = 1'b0;
    end else if (e && !m_open) begin
      m_word = d;
      m_open = 1'b1;
    end else if (!e) begin
      m_open = 1'b0;
    end
    #1;
    check({tag, ".data"}, 32'(data_out), 32'(m_word));
    check({tag, ".fim"},  32'(fim),      32'(m_open));
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic             re;
    logic             rr;
    n_checks = 0;
    n_errors = 0;
    m_word   = '0;
    m_open   = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    data_in  = '0;

    // Reset with en high and all-ones data: no capture is allowed.
    cycle("reset", 1'b1, 1'b1, 6'b111111);
    check("reset.const_data", 32'(data_out), 32'h0);
    check("reset.const_fim",  32'(fim),      32'h0);

    // Basic load, then hold while data_in changes.
    cycle("load", 1'b0, 1'b1, 6'b101010);
    check("load.const_data", 32'(data_out), 32'h2a);
    cycle("hold1", 1'b0, 1'b1, 6'b110000);
    cycle("hold2", 1'b0, 1'b1, 6'b110000);
    check("hold.const_data", 32'(data_out), 32'h2a);
    check("hold.const_fim",  32'(fim),      32'h1);

    // Release, then a second handshake.
    cycle("release", 1'b0, 1'b0, 6'b110000);
    check("release.const_data", 32'(data_out), 32'h2a);
    cycle("reload", 1'b0, 1'b1, 6'b000111);
    check("reload.const_data", 32'(data_out), 32'h07);

    // Reset mid-handshake with en held; capture resumes right after reset.
    cycle("midrst", 1'b1, 1'b1, 6'b000111);
    cycle("postrst", 1'b0, 1'b1, 6'b111000);
    check("postrst.const_data", 32'(data_out), 32'h38);

    // Single-cycle request: fim is a one-cycle pulse.
    cycle("gap", 1'b0, 1'b0, 6'b000000);
    cycle("pulse", 1'b0, 1'b1, 6'b010101);
    check("pulse.const_fim", 32'(fim), 32'h1);
    cycle("pulse_end", 1'b0, 1'b0, 6'b111111);
    check("pulse_end.const_fim",  32'(fim),      32'h0);
    check("pulse_end.const_data", 32'(data_out), 32'h15);

    // Randomized traffic: en tends to persist so holds and releases both occur.
    re = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) re = ~re;
      rr = ($urandom_range(0, 39) == 0);
      rd = WIDTH'($urandom);
      cycle("rand", rr, re, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg6_handshake.md
Name: reg6_handshake

Overview:
- Parameterised data register (default 6 bits) loaded through a four-phase request/acknowledge handshake.
- Producer raises `en` with valid `data_in`; block captures the word once and raises `fim` (done).
- `fim` and `data_out` stay stable until the producer drops `en`; only then does the block re-arm.
- Used as a simple handoff register between a producer FSM and downstream logic in the same clock domain.

Parameters:
- WIDTH, 6, width of `data_in` and `data_out` in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- en  input  1  request; high means `data_in` is valid and a load is requested.
- data_in  input  WIDTH  word to capture.
- data_out  output  WIDTH  registered captured word.
- fim  output  1  registered acknowledge/done flag.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- Reset (any edge with rst=1, in any state): state=IDLE, data_out=0, fim=0.
- Reset has priority over every other condition, including mid-handshake.
- States: IDLE (armed, fim=0) and DONE (captured, fim=1). Encoding is free; the FSM has no other reachable states.
- IDLE, en=0: hold; data_out keeps its last captured value (not cleared).
- IDLE, en=1 at edge k: data_out <= data_in sampled at edge k; fim <= 1; state <= DONE.
  - Latency: data_out and fim are valid one edge after `en` is first seen high (i.e. right after edge k).
- DONE, en=1: hold. data_out does not follow later changes of `data_in`; exactly one capture per handshake.
- DONE, en=0 at edge m: fim <= 0; state <= IDLE; data_out retained.
- Re-arm rule: a new capture requires at least one edge with en=0 sampled in DONE, then en=1 sampled in IDLE.
  - A continuously high `en` therefore never produces a second capture.
- en pulse of a single cycle in IDLE: capture happens. fim rises, then falls on the next edge where en=0 is sampled, giving a one-cycle fim pulse.
- Unknown/illegal state, if ever reached: next edge goes to IDLE with fim=0.
- Width: data_in is captured at full WIDTH, with no truncation or extension.

Test Plan:
1. Reset: rst=1 for one edge with data_in=6'b111111, en=1 -> after that edge data_out=6'b000000, fim=0; no capture occurs while rst=1.
2. Basic load: rst=0, data_in=6'b101010, en=1 -> one edge later data_out=6'b101010, fim=1.
3. Hold while requested: en stays 1, data_in changes to 6'b110000 for 2 cycles -> data_out remains 6'b101010, fim remains 1.
4. Release: en=0 -> next edge fim=0, data_out stays 6'b101010.
   - Then en=1 with data_in=6'b000111 -> one edge later data_out=6'b000111, fim=1.
5. Reset mid-handshake: in DONE with data_out=6'b000111, assert rst=1 for one edge while en=1 -> data_out=0, fim=0.
   - Then rst=0 with en still 1 -> next edge captures current data_in and fim=1.
6. Single-cycle request: en high for exactly one edge with data_in=6'b010101 -> data_out=6'b010101; fim high for exactly one cycle, then 0.
